// File: rtl/game_pkg.sv
// Shared definitions for the Snake game sequencer and the VGA wrapper.
// Holds the MASTER_STATE encoding, the state typedef and counter widths.
// The package has no ports; importers use game_pkg::*.
package game_pkg;

  // Display-facing game state. The VGA wrapper decodes these same values,
  // so the encoding must not change. 2'd3 is never produced.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WON  = 2'd2
  } state_t;

  // tick_cnt covers TICK_FRAMES up to 255 and won_cnt covers WON_FRAMES up
  // to 1023.
  localparam int TICK_CNT_W = 8;
  localparam int WON_CNT_W  = 10;

  // A start press is only meaningful when no game is running.
  function automatic logic accepts_start(input state_t st);
    return (st == ST_IDLE) || (st == ST_WON);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Level debouncer: dout follows din only after din has differed from dout
// for CYCLES consecutive clocks. Any shorter disagreement restarts the count.
// Ports: clk, rst_n (async, active low), din (already synchronized), dout.
module btn_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int               CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  // Number of consecutive cycles din has already disagreed with dout.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      // Agreement, including the end of a glitch, restarts the window.
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      // This is the CYCLES-th disagreeing cycle: accept the new level.
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Master game sequencer for the Snake display path: produces MASTER_STATE
// (0 idle, 1 play, 2 won), a one-cycle FRAME_START per VGA frame and the
// per-step TICK. State changes happen only on frame boundaries.
//
// Ports:
//   CLK           system clock shared with the VGA wrapper
//   RESET_N       asynchronous active-low reset
//   VS            VGA vertical sync, active low, synchronous to CLK
//   BTN_START     raw asynchronous start button, active high
//   WIN, LOSE     one-cycle pulses from the game logic
//   MASTER_STATE  registered game state (game_pkg::state_t encoding)
//   TICK          registered one-cycle game-step pulse
//   FRAME_START   registered one-cycle pulse per frame
//
// Build option: define GAME_BTN_DEBOUNCE_EN to insert btn_debounce between
// the button synchronizer and the press edge detector. Without it the
// synchronized level is used directly and DEBOUNCE_CYCLES has no effect.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int TICK_FRAMES     = 6,
  parameter int WON_FRAMES      = 180,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       VS,
  input  logic       BTN_START,
  input  logic       WIN,
  input  logic       LOSE,
  output logic [1:0] MASTER_STATE,
  output logic       TICK,
  output logic       FRAME_START
);

  localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(TICK_FRAMES - 1);
  localparam logic [WON_CNT_W-1:0]  WON_LAST  = WON_CNT_W'(WON_FRAMES - 1);

  // ---------------------------------------------------------------------
  // Frame detection
  // ---------------------------------------------------------------------
  // vs_cur is the latest VS sample, vs_hist the one before it. Both reset
  // high so that leaving reset never looks like a VS falling edge.
  logic vs_cur;
  logic vs_hist;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_cur      <= 1'b1;
      vs_hist     <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      vs_cur      <= VS;
      vs_hist     <= vs_cur;
      FRAME_START <= vs_hist & ~vs_cur;
    end
  end

  // ---------------------------------------------------------------------
  // Start button: synchronizer, optional debounce, rising-edge detect
  // ---------------------------------------------------------------------
  logic btn_meta;
  logic btn_sync;
  logic btn_lvl;
  logic btn_lvl_q;
  logic press;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
      btn_lvl_q <= 1'b0;
    end else begin
      btn_meta  <= BTN_START;
      btn_sync  <= btn_meta;
      btn_lvl_q <= btn_lvl;
    end
  end

`ifdef GAME_BTN_DEBOUNCE_EN
  btn_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (CLK),
    .rst_n (RESET_N),
    .din   (btn_sync),
    .dout  (btn_lvl)
  );
`else
  // No debouncer: any non-negative debounce length selects the direct path.
  if (DEBOUNCE_CYCLES >= 0) begin : g_btn_direct
    assign btn_lvl = btn_sync;
  end
`endif

  assign press = btn_lvl & ~btn_lvl_q;

  // ---------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------
  state_t state_q;
  state_t state_nxt;

  logic start_pend;
  logic win_pend;
  logic lose_pend;
  logic start_pend_nxt;
  logic win_pend_nxt;
  logic lose_pend_nxt;

  logic [TICK_CNT_W-1:0] tick_cnt;
  logic [TICK_CNT_W-1:0] tick_cnt_nxt;
  logic [WON_CNT_W-1:0]  won_cnt;
  logic [WON_CNT_W-1:0]  won_cnt_nxt;
  logic                  tick_nxt;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: only evaluated on a frame boundary, using the requests
  // collected during the frame that is just ending.
  always_comb begin
    state_nxt = state_q;
    if (FRAME_START) begin
      case (state_q)
        ST_IDLE: begin
          if (start_pend) state_nxt = ST_PLAY;
        end
        ST_PLAY: begin
          // Losing wins the tie when both arrive in the same frame.
          if (lose_pend)     state_nxt = ST_IDLE;
          else if (win_pend) state_nxt = ST_WON;
        end
        ST_WON: begin
          if (start_pend || (won_cnt == WON_LAST)) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs, counters and pending requests derived from the transition.
  always_comb begin
    tick_cnt_nxt = tick_cnt;
    won_cnt_nxt  = won_cnt;
    tick_nxt     = 1'b0;

    if (FRAME_START) begin
      // Steady play frame: advance the step counter, tick on wrap.
      if ((state_q == ST_PLAY) && (state_nxt == ST_PLAY)) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt_nxt = '0;
          tick_nxt     = 1'b1;
        end else begin
          tick_cnt_nxt = tick_cnt + 1'b1;
        end
      end
      // Entering play restarts step pacing; the entry frame never ticks.
      if ((state_q == ST_IDLE) && (state_nxt == ST_PLAY)) begin
        tick_cnt_nxt = '0;
      end
      if ((state_q == ST_PLAY) && (state_nxt == ST_WON)) begin
        won_cnt_nxt = '0;
      end
      if ((state_q == ST_WON) && (state_nxt == ST_WON)) begin
        won_cnt_nxt = won_cnt + 1'b1;
      end
    end

    // Flags clear on the boundary, but an event in the boundary cycle
    // itself is kept and applies to the following frame.
    start_pend_nxt = (FRAME_START ? 1'b0 : start_pend)
                   | (press & accepts_start(state_q));
    win_pend_nxt   = (FRAME_START ? 1'b0 : win_pend)
                   | (WIN & (state_q == ST_PLAY));
    lose_pend_nxt  = (FRAME_START ? 1'b0 : lose_pend)
                   | (LOSE & (state_q == ST_PLAY));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      start_pend <= 1'b0;
      win_pend   <= 1'b0;
      lose_pend  <= 1'b0;
      tick_cnt   <= '0;
      won_cnt    <= '0;
      TICK       <= 1'b0;
    end else begin
      start_pend <= start_pend_nxt;
      win_pend   <= win_pend_nxt;
      lose_pend  <= lose_pend_nxt;
      tick_cnt   <= tick_cnt_nxt;
      won_cnt    <= won_cnt_nxt;
      TICK       <= tick_nxt;
    end
  end

  assign MASTER_STATE = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl (plus a standalone btn_debounce).
// Two DUTs share the inputs: TICK_FRAMES=6/WON_FRAMES=4 and the 1/1 corner.
// A frame-level reference model is compared against both on every cycle.
`timescale 1ns/1ps
module tb_game_state_ctrl;

  localparam int TF  = 6;
  localparam int WF  = 4;
  localparam int DEB = 16;
`ifdef GAME_BTN_DEBOUNCE_EN
  localparam int PRESS_LEN = 24;
  localparam int FRAME_LEN = 80;
`else
  localparam int PRESS_LEN = 4;
  localparam int FRAME_LEN = 20;
`endif

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic VS = 1'b1;
  logic BTN_START = 1'b0;
  logic WIN = 1'b0;
  logic LOSE = 1'b0;
  logic [1:0] ms_a, ms_b;
  logic tick_a, tick_b, fs_a, fs_b;
  logic deb_din = 1'b0;
  logic deb_dout;
  bit   chk_en = 1'b0;
  bit   rand_frames = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  game_state_ctrl #(.TICK_FRAMES(TF), .WON_FRAMES(WF), .DEBOUNCE_CYCLES(DEB)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .VS(VS), .BTN_START(BTN_START), .WIN(WIN), .LOSE(LOSE),
    .MASTER_STATE(ms_a), .TICK(tick_a), .FRAME_START(fs_a));

  game_state_ctrl #(.TICK_FRAMES(1), .WON_FRAMES(1), .DEBOUNCE_CYCLES(DEB)) u_dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .VS(VS), .BTN_START(BTN_START), .WIN(WIN), .LOSE(LOSE),
    .MASTER_STATE(ms_b), .TICK(tick_b), .FRAME_START(fs_b));

  btn_debounce #(.CYCLES(DEB)) u_deb (
    .clk(CLK), .rst_n(RESET_N), .din(deb_din), .dout(deb_dout));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level rules) ----------------
  typedef struct {
    int st;                       // 0 idle, 1 play, 2 won
    bit sp, wp, lp;               // requests collected this frame
    int play_frames, won_frames;  // frames since entering play / won
    bit tick, fs;                 // expected registered outputs
    bit v1, v2;                   // VS sampled 1 and 2 edges ago
    bit b1, b2;                   // button sampled 1 and 2 edges ago
    bit lvl_prev;                 // button level seen on the previous edge
    bit deb;                      // debounced level
    int deb_run;                  // consecutive disagreeing cycles
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = 0; m.sp = 0; m.wp = 0; m.lp = 0;
    m.play_frames = 0; m.won_frames = 0;
    m.tick = 0; m.fs = 0; m.v1 = 1; m.v2 = 1;
    m.b1 = 0; m.b2 = 0; m.lvl_prev = 0; m.deb = 0; m.deb_run = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit vs, input bit btn,
                                    input bit win, input bit lose, input int tf, input int wf);
    mdl_t n;
    bit lvl, press;
    n = m;
`ifdef GAME_BTN_DEBOUNCE_EN
    lvl = m.deb;
    if (m.b2 != m.deb) begin
      n.deb_run = m.deb_run + 1;
      if (n.deb_run == DEB) begin n.deb = m.b2; n.deb_run = 0; end
    end else begin
      n.deb_run = 0;
    end
`else
    lvl = m.b2;
`endif
    press = lvl && !m.lvl_prev;
    n.lvl_prev = lvl;
    n.tick = 0;
    if (m.fs) begin
      case (m.st)
        0: if (m.sp) begin n.st = 1; n.play_frames = 0; end
        1: begin
          if (m.lp) n.st = 0;
          else if (m.wp) begin n.st = 2; n.won_frames = 0; end
          else begin
            n.play_frames = m.play_frames + 1;
            n.tick = (n.play_frames % tf) == 0;
          end
        end
        default: begin
          n.won_frames = m.won_frames + 1;
          if (m.sp || n.won_frames == wf) n.st = 0;
        end
      endcase
      n.sp = 0; n.wp = 0; n.lp = 0;
    end
    if (press && m.st != 1) n.sp = 1;
    if (win && m.st == 1) n.wp = 1;
    if (lose && m.st == 1) n.lp = 1;
    n.fs = m.v2 && !m.v1;
    n.v2 = m.v1; n.v1 = vs;
    n.b2 = m.b1; n.b1 = btn;
    return n;
  endfunction

  mdl_t ma, mb;
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ma <= mdl_reset();
      mb <= mdl_reset();
    end else begin
      ma <= mdl_step(ma, VS, BTN_START, WIN, LOSE, TF, WF);
      mb <= mdl_step(mb, VS, BTN_START, WIN, LOSE, 1, 1);
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("state", 32'(ms_a), 32'(ma.st));
      check("tick", 32'(tick_a), 32'(ma.tick));
      check("frame_start", 32'(fs_a), 32'(ma.fs));
      check("state_tf1", 32'(ms_b), 32'(mb.st));
      check("tick_tf1", 32'(tick_b), 32'(mb.tick));
    end
  end

  // ---------------- VS generator ----------------
  initial begin
    int len, low;
    forever begin
      len = rand_frames ? int'($urandom_range(FRAME_LEN / 2, FRAME_LEN * 3 / 2)) : FRAME_LEN;
      low = rand_frames ? int'($urandom_range(1, 3)) : 3;
      for (int i = 0; i < len; i++) begin
        @(negedge CLK);
        VS = (i < low) ? 1'b0 : 1'b1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_frames(input int n, output int ticks);
    int seen, budget;
    seen = 0; ticks = 0; budget = n * FRAME_LEN * 2 + 50;
    while (seen < n && budget > 0) begin
      @(negedge CLK); budget--;
      if (fs_a) seen++;
      if (tick_a) ticks++;
    end
    if (seen < n) check("frame_wait_timeout", 32'(seen), 32'(n));
    repeat (2) begin
      @(negedge CLK);
      if (tick_a) ticks++;
    end
  endtask

  task automatic pulse(input bit p, input bit w, input bit l);
    @(negedge CLK);
    WIN = w; LOSE = l;
    if (p) BTN_START = 1'b1;
    @(negedge CLK);
    WIN = 1'b0; LOSE = 1'b0;
    repeat (PRESS_LEN - 1) @(negedge CLK);
    BTN_START = 1'b0;
  endtask

  typedef struct {
    bit press, win, lose;
    int frames, exp_state, exp_ticks;
  } vec_t;

  function automatic vec_t mk(input bit p, input bit w, input bit l,
                              input int f, input int s, input int t);
    vec_t v;
    v.press = p; v.win = w; v.lose = l; v.frames = f; v.exp_state = s; v.exp_ticks = t;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl[15];
    int ticks, budget;

    tbl[0]  = mk(1, 0, 0, 1, 1, 0);   // press in idle -> play, entry frame no tick
    tbl[1]  = mk(0, 0, 0, 5, 1, 0);   // frames 1..5 of play
    tbl[2]  = mk(0, 0, 0, 1, 1, 1);   // 6th frame ticks
    tbl[3]  = mk(0, 0, 0, 6, 1, 1);   // next tick 6 frames later
    tbl[4]  = mk(1, 0, 0, 3, 1, 0);   // press in play ignored
    tbl[5]  = mk(0, 1, 0, 1, 2, 0);   // win -> won, no tick on transition
    tbl[6]  = mk(0, 0, 0, 3, 2, 0);   // held in won
    tbl[7]  = mk(0, 0, 0, 1, 0, 0);   // 4th won frame -> idle
    tbl[8]  = mk(0, 0, 1, 1, 0, 0);   // lose in idle ignored
    tbl[9]  = mk(1, 0, 0, 1, 1, 0);
    tbl[10] = mk(0, 1, 1, 1, 0, 0);   // lose beats win
    tbl[11] = mk(1, 0, 0, 1, 1, 0);
    tbl[12] = mk(0, 1, 0, 1, 2, 0);
    tbl[13] = mk(1, 0, 0, 1, 0, 0);   // press in won -> idle
    tbl[14] = mk(0, 0, 0, 2, 0, 0);   // that press does not restart play

    chk_en = 1'b1;
    repeat (30) @(negedge CLK);
    #2 RESET_N = 1'b1;

    wait_frames(1, ticks);
    for (int i = 0; i < 15; i++) begin
      pulse(tbl[i].press, tbl[i].win, tbl[i].lose);
      wait_frames(tbl[i].frames, ticks);
      check($sformatf("tbl%0d_state", i), 32'(ms_a), 32'(tbl[i].exp_state));
      check($sformatf("tbl%0d_ticks", i), 32'(ticks), 32'(tbl[i].exp_ticks));
    end

    // LOSE in the FRAME_START cycle applies one frame later.
    pulse(1, 0, 0);
    wait_frames(1, ticks);
    check("seq_enter_play", 32'(ms_a), 32'd1);
    budget = FRAME_LEN * 3;
    do begin @(negedge CLK); budget--; end while (!fs_a && budget > 0);
    check("seq_fs_found", 32'(fs_a), 32'd1);
    LOSE = 1'b1;
    @(negedge CLK);
    LOSE = 1'b0;
    check("seq_lose_on_fs_hold", 32'(ms_a), 32'd1);
    wait_frames(1, ticks);
    check("seq_lose_next_frame", 32'(ms_a), 32'd0);

    // Asynchronous reset in play returns outputs to zero immediately.
    pulse(1, 0, 0);
    wait_frames(1, ticks);
    check("seq_play_before_reset", 32'(ms_a), 32'd1);
    #2 RESET_N = 1'b0;
    #1 check("seq_async_reset_state", 32'(ms_a), 32'd0);
    check("seq_async_reset_tick", 32'(tick_a), 32'd0);
    repeat (2) @(negedge CLK);
    #2 RESET_N = 1'b1;

    // Standalone debouncer.
    @(negedge CLK);
    deb_din = 1'b1;
    repeat (10) @(negedge CLK);
    deb_din = 1'b0;
    ticks = 0;
    repeat (30) begin @(negedge CLK); if (deb_dout) ticks++; end
    check("deb_short_pulse", 32'(ticks), 32'd0);
    deb_din = 1'b1;
    repeat (15) @(negedge CLK);
    check("deb_rise_early", 32'(deb_dout), 32'd0);
    @(negedge CLK);
    check("deb_rise_on_time", 32'(deb_dout), 32'd1);
    repeat (4) @(negedge CLK);
    deb_din = 1'b0;
    repeat (15) @(negedge CLK);
    check("deb_fall_early", 32'(deb_dout), 32'd1);
    @(negedge CLK);
    check("deb_fall_on_time", 32'(deb_dout), 32'd0);
    deb_din = 1'b1;
    repeat (10) @(negedge CLK);
    deb_din = 1'b0;
    @(negedge CLK);
    deb_din = 1'b1;
    repeat (15) @(negedge CLK);
    check("deb_glitch_restart", 32'(deb_dout), 32'd0);
    @(negedge CLK);
    check("deb_after_glitch", 32'(deb_dout), 32'd1);
    deb_din = 1'b0;

    // Randomized traffic against the model.
    rand_frames = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge CLK);
      WIN  = ($urandom_range(0, 149) == 0);
      LOSE = ($urandom_range(0, 199) == 0);
`ifdef GAME_BTN_DEBOUNCE_EN
      if ($urandom_range(0, 39) == 0) BTN_START = ~BTN_START;
`else
      if ($urandom_range(0, 24) == 0) BTN_START = ~BTN_START;
`endif
      if ($urandom_range(0, 1999) == 0) begin
        #2 RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        #3 RESET_N = 1'b1;
      end
    end
    WIN = 1'b0; LOSE = 1'b0; BTN_START = 1'b0;
    repeat (5) @(negedge CLK);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
